// File: rtl/alu_seq_n_bits_if.sv
// -----------------------------------------------------------------------------
// alu_seq_n_bits_if
// Request/response bundle between the operand front end and alu_seq_n_bits.
//
// Handshake: the master raises start with a, b and control valid. The ALU
// accepts the request on a rising edge only while busy=0; the operands are
// latched at that edge and busy rises. Later input changes are ignored until
// done. done is a one-cycle pulse. result and the flags are valid in that
// cycle and hold until the next done. Holding start high through the done
// cycle starts the next operation with no idle gap.
//
// Parameters: N - operand/result width (N >= 2)
// master: drives start, a, b, control; receives result, v, c, n, z, dz, busy, done
// slave : the ALU side of the same signals
// -----------------------------------------------------------------------------
interface alu_seq_n_bits_if #(parameter int N = 4);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   control;
    logic [N-1:0] result;
    logic         v;
    logic         c;
    logic         n;
    logic         z;
    logic         dz;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b, control,
        input  result, v, c, n, z, dz, busy, done
    );

    modport slave (
        input  start, a, b, control,
        output result, v, c, n, z, dz, busy, done
    );
endinterface

// File: rtl/alu_seq_n_bits.sv
// -----------------------------------------------------------------------------
// alu_seq_n_bits
// Multi-cycle N-bit ALU with a start/done handshake and registered outputs.
// Supported ops: add, sub, and, or, xor, lsr, lsl, mod, mul and div. Codes
// 10-15 are illegal and return result=0 with z=1. div and mod use a restoring
// divider that produces one quotient bit per cycle over N cycles.
//
// Macro ALU_MUL_EN: when defined, op 8 is an N-cycle shift-add multiply whose
// result is the low half of the product. c and v are set when the high half
// is nonzero. When the macro is undefined, op 8 passes a through in one cycle.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   bus       - alu_seq_n_bits_if.slave (start/a/b/control in; result,
//               v/c/n/z/dz flags, busy, done out)
//   state_dbg - current FSM state (0 IDLE, 1 CALC, 2 FINISH)
// -----------------------------------------------------------------------------
module alu_seq_n_bits #(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_seq_n_bits_if.slave        bus,
    output logic [1:0]             state_dbg
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [3:0]    ctl_r;
    logic [CW-1:0] cnt;
    logic [N-1:0]  quot_r;   // dividend shifts out of the top, quotient bits shift in
    logic [N-1:0]  rem_r;
`ifdef ALU_MUL_EN
    logic [2*N-1:0] prod_r;
    logic [2*N-1:0] mcand_r;
    logic [N-1:0]   mplier_r;
`endif

    logic           start_iter;
    logic [N:0]     trial;
    logic           trial_ge;
    logic [N-1:0]   rem_step;
    logic [N-1:0]   quot_step;
    logic [N:0]     sum_add;
    logic [N:0]     sum_sub;
    logic [N-1:0]   res_nx;
    logic           c_nx;
    logic           v_nx;
    logic           dz_nx;

    assign state_dbg = state;

    // Operations that go through CALC. A zero divisor uses the single-cycle path.
    always_comb begin
        start_iter = 1'b0;
        if ((bus.control == 4'd7 || bus.control == 4'd9) && bus.b != '0)
            start_iter = 1'b1;
`ifdef ALU_MUL_EN
        if (bus.control == 4'd8)
            start_iter = 1'b1;
`endif
    end

    // One restoring-division step: bring down the next dividend bit and
    // subtract the divisor if it fits. The remainder stays below b, so N bits
    // are enough to hold it.
    always_comb begin
        trial     = {rem_r, quot_r[N-1]};
        trial_ge  = (trial >= {1'b0, b_r});
        rem_step  = trial_ge ? N'(trial - {1'b0, b_r}) : trial[N-1:0];
        quot_step = {quot_r[N-2:0], trial_ge};
    end

    // Result selection from the latched operands and the iterative unit state.
    always_comb begin
        sum_add = {1'b0, a_r} + {1'b0, b_r};
        sum_sub = {1'b0, a_r} + {1'b0, ~b_r} + (N+1)'(1);
        res_nx  = '0;
        c_nx    = 1'b0;
        v_nx    = 1'b0;
        dz_nx   = 1'b0;
        case (ctl_r)
            4'd0: begin
                res_nx = sum_add[N-1:0];
                c_nx   = sum_add[N];
                v_nx   = (a_r[N-1] == b_r[N-1]) && (sum_add[N-1] != a_r[N-1]);
            end
            4'd1: begin
                res_nx = sum_sub[N-1:0];
                c_nx   = sum_sub[N];
                v_nx   = (a_r[N-1] != b_r[N-1]) && (sum_sub[N-1] != a_r[N-1]);
            end
            4'd2: res_nx = a_r & b_r;
            4'd3: res_nx = a_r | b_r;
            4'd4: res_nx = a_r ^ b_r;
            4'd5: res_nx = (b_r >= N'(N)) ? '0 : (a_r >> b_r);
            4'd6: res_nx = (b_r >= N'(N)) ? '0 : (a_r << b_r);
            4'd7: begin
                if (b_r == '0) begin
                    res_nx = a_r;
                    dz_nx  = 1'b1;
                end else begin
                    res_nx = rem_r;
                end
            end
            4'd8: begin
`ifdef ALU_MUL_EN
                res_nx = prod_r[N-1:0];
                c_nx   = |prod_r[2*N-1:N];
                v_nx   = |prod_r[2*N-1:N];
`else
                res_nx = a_r;
`endif
            end
            4'd9: begin
                if (b_r == '0) begin
                    res_nx = '1;
                    dz_nx  = 1'b1;
                end else begin
                    res_nx = quot_r;
                end
            end
            default: res_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            ctl_r      <= '0;
            cnt        <= '0;
            quot_r     <= '0;
            rem_r      <= '0;
`ifdef ALU_MUL_EN
            prod_r     <= '0;
            mcand_r    <= '0;
            mplier_r   <= '0;
`endif
            bus.result <= '0;
            bus.v      <= 1'b0;
            bus.c      <= 1'b0;
            bus.n      <= 1'b0;
            bus.z      <= 1'b0;
            bus.dz     <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        ctl_r    <= bus.control;
                        quot_r   <= bus.a;
                        rem_r    <= '0;
`ifdef ALU_MUL_EN
                        prod_r   <= '0;
                        mcand_r  <= {{N{1'b0}}, bus.a};
                        mplier_r <= bus.b;
`endif
                        cnt      <= CW'(N - 1);
                        bus.busy <= 1'b1;
                        state    <= start_iter ? CALC : FINISH;
                    end
                end
                CALC: begin
                    // Divider and multiplier advance together; ctl_r decides
                    // which result FINISH takes.
                    quot_r <= quot_step;
                    rem_r  <= rem_step;
`ifdef ALU_MUL_EN
                    if (mplier_r[0])
                        prod_r <= prod_r + mcand_r;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
`endif
                    if (cnt == '0)
                        state <= FINISH;
                    else
                        cnt <= cnt - 1'b1;
                end
                FINISH: begin
                    bus.result <= res_nx;
                    bus.c      <= c_nx;
                    bus.v      <= v_nx;
                    bus.n      <= res_nx[N-1];
                    bus.z      <= (res_nx == '0);
                    bus.dz     <= dz_nx;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_n_bits.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_n_bits
// Directed plus randomised checks for alu_seq_n_bits (N=4). Expected words are
// {result, v, c, n, z, dz}. They are queued when an operation is driven and
// compared when done is seen. Build with or without ALU_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu_seq_n_bits;
    localparam int N = 4;
    localparam int W = N + 5;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    alu_seq_n_bits_if #(.N(N)) bus ();

    alu_seq_n_bits #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] obs_word();
        return {bus.result, bus.v, bus.c, bus.n, bus.z, bus.dz};
    endfunction

    // reference model: integer arithmetic on the unsigned operand values
    function automatic logic [W-1:0] model(input int ctl, input int a, input int b);
        int   mask, half, r, sa, sb, s, p;
        logic v, c, dz;
        mask = (1 << N) - 1;
        half = 1 << (N - 1);
        sa   = (a >= half) ? a - (1 << N) : a;
        sb   = (b >= half) ? b - (1 << N) : b;
        r = 0; v = 1'b0; c = 1'b0; dz = 1'b0; s = 0; p = 0;
        case (ctl)
            0: begin r = a + b; c = (r > mask); s = sa + sb; v = (s >= half) || (s < -half); end
            1: begin r = a - b; c = (a >= b);   s = sa - sb; v = (s >= half) || (s < -half); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (b >= N) ? 0 : (a >> b);
            6: r = (b >= N) ? 0 : (a << b);
            7: if (b == 0) begin r = a; dz = 1'b1; end else r = a % b;
            8: begin
`ifdef ALU_MUL_EN
                p = a * b; r = p; c = ((p >> N) != 0); v = c;
`else
                r = a;
`endif
            end
            9: if (b == 0) begin r = mask; dz = 1'b1; end else r = a / b;
            default: r = 0;
        endcase
        r = r & mask;
        return {r[N-1:0], v, c, r[N-1], (r == 0), dz};
    endfunction

    function automatic int model_lat(input int ctl, input int b);
        if ((ctl == 7 || ctl == 9) && b != 0) return N + 1;
`ifdef ALU_MUL_EN
        if (ctl == 8) return N + 1;
`endif
        return 1;
    endfunction

    // driver: one operation with start released after acceptance
    task automatic run_op(input string tag, input int ctl, input int av, input int bv,
                          input logic [W-1:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.control = ctl[3:0];
        bus.a       = av[N-1:0];
        bus.b       = bv[N-1:0];
        exp_q.push_back(exp);
        @(posedge clk); #1;
        check({tag, "_busy_t0"}, 32'(bus.busy), 1);
        // operand changes while busy must not matter
        bus.start   = 1'b0;
        bus.control = 4'($urandom_range(0, 15));
        bus.a       = N'($urandom_range(0, (1 << N) - 1));
        bus.b       = N'($urandom_range(0, (1 << N) - 1));
        lat = 0;
        while (bus.done !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, 32'(obs_word()), 32'(exp_q.pop_front()));
        check({tag, "_busy_done"}, 32'(bus.busy), 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 0);
    endtask

    initial begin
        int seen_done;
        int ctl, av, bv;

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.control = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({obs_word(), bus.busy, bus.done}), 0);
        check("reset_state", 32'(state_dbg), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_op("add_7_9",  0, 7, 9,  {4'h0, 5'b01010}, 1);
        run_op("sub_4_5",  1, 4, 5,  {4'hF, 5'b00100}, 1);
        run_op("add_7_1",  0, 7, 1,  {4'h8, 5'b10100}, 1);
        run_op("div_13_4", 9, 13, 4, {4'h3, 5'b00000}, N + 1);
        run_op("mod_13_4", 7, 13, 4, {4'h1, 5'b00000}, N + 1);
        run_op("div_6_0",  9, 6, 0,  {4'hF, 5'b00101}, 1);
        run_op("mod_6_0",  7, 6, 0,  {4'h6, 5'b00001}, 1);
`ifdef ALU_MUL_EN
        run_op("mul_5_6",  8, 5, 6,  {4'hE, 5'b11100}, N + 1);
`else
        run_op("mul_5_6",  8, 5, 6,  {4'h5, 5'b00000}, 1);
`endif
        run_op("lsr_9_4",  5, 9, 4,  {4'h0, 5'b00010}, 1);
        run_op("lsr_12_2", 5, 12, 2, {4'h3, 5'b00000}, 1);
        run_op("illegal",  12, 9, 3, {4'h0, 5'b00010}, 1);

        // back-to-back: start held high through the done cycle
        @(negedge clk);
        bus.start = 1'b1; bus.control = 4'd4; bus.a = 4'd5; bus.b = 4'd3;
        exp_q.push_back({4'h6, 5'b00000});
        @(posedge clk); #1;                     // t0
        @(posedge clk); #1;                     // t0+1
        check("b2b_done1", 32'(bus.done), 1);
        check("b2b_res1", 32'(obs_word()), 32'(exp_q.pop_front()));
        bus.control = 4'd2; bus.a = 4'd12; bus.b = 4'd10;
        exp_q.push_back({4'h8, 5'b00100});
        @(posedge clk); #1;                     // accepted again
        check("b2b_busy2", 32'(bus.busy), 1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("b2b_done2", 32'(bus.done), 1);
        check("b2b_res2", 32'(obs_word()), 32'(exp_q.pop_front()));

        // abort: start div, poke start while busy, reset at t0+2
        @(negedge clk);
        bus.start = 1'b1; bus.control = 4'd9; bus.a = 4'd13; bus.b = 4'd4;
        @(posedge clk); #1;                     // t0
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.control = 4'd0; bus.a = 4'd1; bus.b = 4'd1;
        @(posedge clk); #1;                     // t0+1
        check("abort_busy", 32'(bus.busy), 1);
        check("abort_no_done", 32'(bus.done), 0);
        bus.start = 1'b0;
        @(posedge clk); #1;                     // t0+2
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({obs_word(), bus.busy, bus.done}), 0);
        check("abort_state", 32'(state_dbg), 0);
        seen_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done++;
        end
        check("abort_done_count", 32'(seen_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("lsl_3_5", 6, 3, 5, {4'h0, 5'b00010}, 1);

        // randomised ops against the model
        for (int i = 0; i < 24; i++) begin
            ctl = $urandom_range(0, 15);
            av  = $urandom_range(0, (1 << N) - 1);
            bv  = (i % 4 == 0) ? 0 : $urandom_range(0, (1 << N) - 1);
            run_op($sformatf("rand%0d_op%0d", i, ctl), ctl, av, bv,
                   model(ctl, av, bv), model_lat(ctl, bv));
        end

        // final report
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
